// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared address/data widths, controller state encoding and I/O address decode.
package mem_ctrl_pkg;

    localparam int ADDR_WID = 32;
    localparam int DATA_WID = 32;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, COOL} state_t;

    function automatic logic is_io(input logic [ADDR_WID-1:0] a);
        return a[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM arbiter serving instruction fetches and load/store requests.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                rollback,
    input  logic [7:0]          mem_din,
    output logic [7:0]          mem_dout,
    output logic [ADDR_WID-1:0] mem_a,
    output logic                mem_wr,
    input  logic                io_buffer_full,
    input  logic                if_en,
    input  logic [ADDR_WID-1:0] if_addr,
    output logic                if_done,
    output logic [DATA_WID-1:0] if_data,
    input  logic                lsb_en,
    input  logic                lsb_wr,
    input  logic [ADDR_WID-1:0] lsb_addr,
    input  logic [2:0]          lsb_len,
    input  logic [DATA_WID-1:0] lsb_w_data,
    output logic                lsb_done,
    output logic [DATA_WID-1:0] lsb_r_data
);

    state_t              state;
    logic [2:0]          cnt;
    logic [2:0]          len;
    logic [ADDR_WID-1:0] base;
    logic [DATA_WID-1:0] wdata;
    logic [DATA_WID-1:0] result;
    logic [DATA_WID-1:0] merged;
    logic                stall;

    // mem_din carries byte cnt-1; at cnt==0 the shift pushes it out entirely
    always_comb merged = result | (DATA_WID'(mem_din) << {cnt - 3'd1, 3'b000});
    always_comb stall = is_io(base) && io_buffer_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            len        <= '0;
            base       <= '0;
            wdata      <= '0;
            result     <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            if_done    <= 1'b0;
            if_data    <= '0;
            lsb_done   <= 1'b0;
            lsb_r_data <= '0;
        end else if (rdy) begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    result <= '0;
                    if (lsb_en) begin
                        state    <= lsb_wr ? STORE : LOAD;
                        base     <= lsb_addr;
                        len      <= lsb_len;
                        wdata    <= lsb_w_data;
                        mem_a    <= lsb_addr;
                        mem_dout <= lsb_w_data[7:0];
                        mem_wr   <= lsb_wr && !(is_io(lsb_addr) && io_buffer_full);
                    end else if (if_en && !rollback) begin
                        state <= FETCH;
                        base  <= if_addr;
                        len   <= 3'd4;
                        mem_a <= if_addr;
                    end
                end
                FETCH, LOAD: begin
                    result <= merged;
                    if (state == FETCH && rollback) begin
                        state <= IDLE;
                    end else if (cnt == len) begin
                        state <= COOL;
                        if (state == FETCH) begin
                            if_done <= 1'b1;
                            if_data <= merged;
                        end else begin
                            lsb_done   <= 1'b1;
                            lsb_r_data <= merged;
                        end
                    end else begin
                        cnt   <= cnt + 3'd1;
                        mem_a <= base + ADDR_WID'(cnt) + 1;
                    end
                end
                STORE: begin
                    // a write only retires when mem_wr was high; otherwise retry the same byte
                    if (!mem_wr) begin
                        mem_wr <= !stall;
                    end else if (cnt == len - 3'd1) begin
                        state    <= COOL;
                        mem_wr   <= 1'b0;
                        lsb_done <= 1'b1;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        mem_a    <= base + ADDR_WID'(cnt) + 1;
                        mem_dout <= wdata[15:8];
                        wdata    <= wdata >> 8;
                        mem_wr   <= !stall;
                    end
                end
                COOL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a byte RAM model with hand-computed results.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        rollback = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_en = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = '0;
    logic [2:0]  lsb_len = '0;
    logic [31:0] lsb_w_data = '0;
    logic        lsb_done;
    logic [31:0] lsb_r_data;

    logic [7:0]  ram [0:255];
    logic [31:0] wr_a [0:63];
    logic [7:0]  wr_d [0:63];
    int          wr_n = 0;
    int          done_n = 0;
    logic        both = 1'b0;
    int          total = 0;
    int          passed = 0;
    int          w0, d0;
    logic        acc;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_done(lsb_done), .lsb_r_data(lsb_r_data)
    );

    always #5 clk = ~clk;

    // RAM answers one cycle after the address; the whole system, RAM included, freezes with rdy
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[7:0]];
        if (mem_wr) begin
            wr_a[wr_n[5:0]] <= mem_a;
            wr_d[wr_n[5:0]] <= mem_dout;
            wr_n <= wr_n + 1;
        end
        if (lsb_done) done_n <= done_n + 1;
        if (if_done && lsb_done) both <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_op(input logic fetch, input logic [31:0] addr, input logic [2:0] len,
                           input logic [31:0] exp);
        if (fetch) begin
            if_en = 1'b1;
            if_addr = addr;
        end else begin
            lsb_en = 1'b1;
            lsb_wr = 1'b0;
            lsb_addr = addr;
            lsb_len = len;
        end
        for (int k = 0; k < int'(len); k++) begin
            tick();
            check("rd_addr", mem_a, addr + 32'(k));
        end
        tick();
        check("rd_early", {30'b0, if_done, lsb_done}, 32'h0);
        tick();
        check("rd_done", {30'b0, if_done, lsb_done}, fetch ? 32'h2 : 32'h1);
        check("rd_data", fetch ? if_data : lsb_r_data, exp);
        if_en = 1'b0;
        lsb_en = 1'b0;
        tick();
    endtask

    task automatic write_op(input logic [31:0] addr, input logic [2:0] len,
                            input logic [31:0] data, input logic full);
        int  ws, ds;
        logic seen;
        ws = wr_n;
        ds = done_n;
        seen = 1'b0;
        lsb_en = 1'b1;
        lsb_wr = 1'b1;
        lsb_addr = addr;
        lsb_len = len;
        lsb_w_data = data;
        io_buffer_full = full;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = lsb_done;
        end
        check("wr_done", {31'b0, seen}, 32'h1);
        lsb_en = 1'b0;
        io_buffer_full = 1'b0;
        tick();
        tick();
        check("wr_count", wr_n - ws, 32'(len));
        for (int k = 0; k < int'(len); k++) begin
            check("wr_a", wr_a[ws + k], addr + 32'(k));
            check("wr_d", {24'b0, wr_d[ws + k]}, (data >> (8 * k)) & 32'hFF);
        end
        check("wr_done_n", done_n - ds, 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        ram[0] = 8'h11;
        ram[1] = 8'h22;
        ram[2] = 8'h33;
        ram[3] = 8'h44;

        tick();
        tick();
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_flags", {28'b0, mem_wr, if_done, lsb_done, 1'b0}, 32'h0);
        check("rst_dout", {24'b0, mem_dout}, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_lsb_data", lsb_r_data, 32'h0);
        rst = 1'b0;

        read_op(1'b0, 32'h100, 3'd4, 32'h44332211);
        read_op(1'b0, 32'hFFFFFFFE, 3'd4, 32'h2211FFFE);
        rollback = 1'b1;
        read_op(1'b0, 32'h0FE, 3'd2, 32'h0000FFFE);
        rollback = 1'b0;

        // simultaneous requests: the byte load goes first
        if_en = 1'b1;
        if_addr = 32'h1040;
        lsb_en = 1'b1;
        lsb_wr = 1'b0;
        lsb_addr = 32'h8;
        lsb_len = 3'd1;
        tick();
        check("pri_addr", mem_a, 32'h8);
        tick();
        tick();
        check("pri_done", {30'b0, if_done, lsb_done}, 32'h1);
        check("pri_data", lsb_r_data, 32'h8);
        lsb_en = 1'b0;
        tick();
        check("pri_cool", {30'b0, mem_wr, if_done}, 32'h0);
        read_op(1'b1, 32'h1040, 3'd4, 32'h43424140);

        // fetch aborted by rollback, then rollback blocks an idle grant
        if_en = 1'b1;
        if_addr = 32'h1000;
        tick();
        check("rb_a0", mem_a, 32'h1000);
        tick();
        rollback = 1'b1;
        acc = 1'b0;
        tick();
        acc = acc | if_done;
        tick();
        acc = acc | if_done;
        if_en = 1'b0;
        rollback = 1'b0;
        check("rb_no_grant", mem_a, 32'h1001);
        repeat (5) begin
            tick();
            acc = acc | if_done;
        end
        check("rb_no_done", {31'b0, acc}, 32'h0);
        write_op(32'h2000, 3'd1, 32'h0000005A, 1'b1);

        // I/O halfword store stalled by a full output buffer
        w0 = wr_n;
        d0 = done_n;
        lsb_en = 1'b1;
        lsb_wr = 1'b1;
        lsb_addr = 32'h30004;
        lsb_len = 3'd2;
        lsb_w_data = 32'hAABBCCDD;
        tick();
        check("io_b0_wr", {31'b0, mem_wr}, 32'h1);
        check("io_b0_a", mem_a, 32'h30004);
        check("io_b0_d", {24'b0, mem_dout}, 32'hDD);
        io_buffer_full = 1'b1;
        acc = 1'b0;
        repeat (3) begin
            tick();
            acc = acc | mem_wr | lsb_done;
        end
        check("io_stall", {31'b0, acc}, 32'h0);
        io_buffer_full = 1'b0;
        tick();
        check("io_b1_wr", {31'b0, mem_wr}, 32'h1);
        check("io_b1_a", mem_a, 32'h30005);
        check("io_b1_d", {24'b0, mem_dout}, 32'hCC);
        tick();
        check("io_done", {30'b0, mem_wr, lsb_done}, 32'h1);
        lsb_en = 1'b0;
        tick();
        tick();
        check("io_done_n", done_n - d0, 32'h1);
        check("io_wr_n", wr_n - w0, 32'h2);

        // rdy low mid-load freezes everything
        lsb_en = 1'b1;
        lsb_wr = 1'b0;
        lsb_addr = 32'h100;
        lsb_len = 3'd4;
        tick();
        check("rdy_a0", mem_a, 32'h100);
        tick();
        check("rdy_a1", mem_a, 32'h101);
        rdy = 1'b0;
        repeat (3) tick();
        check("rdy_hold_a", mem_a, 32'h101);
        check("rdy_hold_done", {31'b0, lsb_done}, 32'h0);
        rdy = 1'b1;
        tick();
        check("rdy_a2", mem_a, 32'h102);
        tick();
        check("rdy_a3", mem_a, 32'h103);
        tick();
        tick();
        check("rdy_done", {31'b0, lsb_done}, 32'h1);
        check("rdy_data", lsb_r_data, 32'h44332211);
        lsb_en = 1'b0;
        tick();

        write_op(32'h0C0, 3'd4, 32'h01020304, 1'b0);

        // reset during byte 2 of a word store
        lsb_en = 1'b1;
        lsb_wr = 1'b1;
        lsb_addr = 32'h2010;
        lsb_len = 3'd4;
        lsb_w_data = 32'h01020304;
        repeat (3) tick();
        check("sw_b2_a", mem_a, 32'h2012);
        check("sw_b2_d", {24'b0, mem_dout}, 32'h02);
        rst = 1'b1;
        lsb_en = 1'b0;
        #1;
        check("mid_rst_a", mem_a, 32'h0);
        check("mid_rst_flags", {29'b0, mem_wr, if_done, lsb_done}, 32'h0);
        check("mid_rst_dout", {24'b0, mem_dout}, 32'h0);
        check("mid_rst_data", if_data | lsb_r_data, 32'h0);
        w0 = wr_n;
        d0 = done_n;
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        check("rst_no_wr", wr_n - w0, 32'h0);
        check("rst_no_done", done_n - d0, 32'h0);

        check("no_coincide", {31'b0, both}, 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
